// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and mux selects, and counts retired instructions.
module multicycle_ctrl #(
    parameter logic [31:0] RESET_INSTRET = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Ins,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  sel_ext,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] instret
);

    // Extender select encodings (Ext_Imm* values)
    localparam logic [2:0] EXT_NONE = 3'b000;
    localparam logic [2:0] EXT_I    = 3'b001;
    localparam logic [2:0] EXT_S    = 3'b010;
    localparam logic [2:0] EXT_B    = 3'b011;
    localparam logic [2:0] EXT_U    = 3'b100;
    localparam logic [2:0] EXT_J    = 3'b101;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_LUI
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [6:0]  w_op;
    logic        w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write;
    logic        w_reg_write, w_instr_done, w_illegal;
    logic [1:0]  w_src_a, w_src_b, w_alu_op, w_result_src;
    logic [31:0] r_instret;
    logic        w_unused_ins;

    assign w_op = Ins[6:0];
    // funct3/funct7 are consumed by the ALU decoder, not by this sequencer
    assign w_unused_ins = ^Ins[31:7];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Next-state and Moore control decode
    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_instr_done = 1'b0;
        w_illegal    = 1'b0;
        w_src_a      = 2'b00;
        w_src_b      = 2'b00;
        w_alu_op     = 2'b00;
        w_result_src = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_src_b      = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = mem_ready;
                w_pc_write   = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_src_a = 2'b01;
                w_src_b = 2'b01;
                case (w_op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    OP_LUI:       w_next = S_LUI;
                    default: begin
                        w_next       = S_FETCH;
                        w_illegal    = 1'b1;
                        w_instr_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_src_a = 2'b10;
                w_src_b = 2'b01;
                w_next  = Ins[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req    = 1'b1;
                w_mem_write  = 1'b1;
                w_adr_src    = 1'b1;
                w_instr_done = mem_ready;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
                w_src_a  = 2'b10;
                w_src_b  = 2'b00;
                w_alu_op = 2'b10;
                w_next   = S_ALUWB;
            end
            S_EXECI: begin
                w_src_a  = 2'b10;
                w_src_b  = 2'b01;
                w_alu_op = 2'b10;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_BEQ: begin
                w_src_a      = 2'b10;
                w_alu_op     = 2'b01;
                w_pc_write   = Zero;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_JAL: begin
                w_src_a    = 2'b01;
                w_src_b    = 2'b10;
                w_pc_write = 1'b1;
                w_next     = S_ALUWB;
            end
            S_LUI: begin
                w_result_src = 2'b11;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Extender select follows the opcode in every state
    always_comb begin
        sel_ext = EXT_NONE;
        case (w_op)
            OP_LW, OP_I: sel_ext = EXT_I;
            OP_SW:       sel_ext = EXT_S;
            OP_BEQ:      sel_ext = EXT_B;
            OP_LUI:      sel_ext = EXT_U;
            OP_JAL:      sel_ext = EXT_J;
            default:     sel_ext = EXT_NONE;
        endcase
    end

    // Retired-instruction counter, wraps silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_instret <= RESET_INSTRET;
        else if (w_instr_done) r_instret <= r_instret + 32'd1;
    end

    // Controls are forced low while reset is held so nothing writes
    assign mem_req    = rst_n & w_mem_req;
    assign MemWrite   = rst_n & w_mem_write;
    assign AdrSrc     = rst_n & w_adr_src;
    assign IRWrite    = rst_n & w_ir_write;
    assign PCWrite    = rst_n & w_pc_write;
    assign RegWrite   = rst_n & w_reg_write;
    assign instr_done = rst_n & w_instr_done;
    assign illegal    = rst_n & w_illegal;
    assign ALUSrcA    = rst_n ? w_src_a      : 2'b00;
    assign ALUSrcB    = rst_n ? w_src_b      : 2'b00;
    assign ALUOp      = rst_n ? w_alu_op     : 2'b00;
    assign ResultSrc  = rst_n ? w_result_src : 2'b00;
    assign instret    = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control vectors and instret.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] Ins;
    logic        Zero;
    logic        mem_ready;

    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, instr_done, illegal;
    logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic [2:0]  sel_ext;
    logic [31:0] instret;

    logic        w2_mem_req, w2_MemWrite, w2_AdrSrc, w2_IRWrite, w2_PCWrite, w2_RegWrite;
    logic        w2_instr_done, w2_illegal;
    logic [1:0]  w2_ALUSrcA, w2_ALUSrcB, w2_ALUOp, w2_ResultSrc;
    logic [2:0]  w2_sel_ext;
    logic [31:0] w2_instret;

    int n_checks = 0;
    int n_err    = 0;

    multicycle_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .Ins(Ins), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ResultSrc(ResultSrc), .sel_ext(sel_ext),
        .instr_done(instr_done), .illegal(illegal), .instret(instret)
    );

    multicycle_ctrl #(.RESET_INSTRET(32'hFFFF_FFFF)) u_wrap (
        .clk(clk), .rst_n(rst_n), .Ins(Ins), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(w2_mem_req), .MemWrite(w2_MemWrite), .AdrSrc(w2_AdrSrc), .IRWrite(w2_IRWrite),
        .PCWrite(w2_PCWrite), .RegWrite(w2_RegWrite), .ALUSrcA(w2_ALUSrcA), .ALUSrcB(w2_ALUSrcB),
        .ALUOp(w2_ALUOp), .ResultSrc(w2_ResultSrc), .sel_ext(w2_sel_ext),
        .instr_done(w2_instr_done), .illegal(w2_illegal), .instret(w2_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_req,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,SrcA,SrcB,ALUOp,ResultSrc,done,illegal}
    logic [15:0] ctl;
    assign ctl = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                  ALUSrcA, ALUSrcB, ALUOp, ResultSrc, instr_done, illegal};

    localparam logic [15:0] C_ZERO    = 16'h0000;
    localparam logic [15:0] C_FETCH_R = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0};
    localparam logic [15:0] C_FETCH_W = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0};
    localparam logic [15:0] C_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b00,1'b0,1'b0};
    localparam logic [15:0] C_DEC_ILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b00,1'b1,1'b1};
    localparam logic [15:0] C_MEMADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,1'b0,1'b0};
    localparam logic [15:0] C_MEMREAD = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [15:0] C_MEMWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b01,1'b1,1'b0};
    localparam logic [15:0] C_MEMWR_W = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [15:0] C_MEMWR_R = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [15:0] C_EXECR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0};
    localparam logic [15:0] C_EXECI   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b10,2'b00,1'b0,1'b0};
    localparam logic [15:0] C_ALUWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [15:0] C_BEQ_T   = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b01,2'b00,1'b1,1'b0};
    localparam logic [15:0] C_BEQ_N   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b01,2'b00,1'b1,1'b0};
    localparam logic [15:0] C_JAL     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b01,2'b10,2'b00,2'b00,1'b0,1'b0};
    localparam logic [15:0] C_LUI     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b11,1'b1,1'b0};

    task automatic chk_ctl(input string tag, input logic [15:0] exp);
        n_checks++;
        assert (ctl === exp) else begin
            n_err++;
            $error("FAIL %s: ctl=%h expected %h", tag, ctl, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got=%h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_ext(input string tag, input logic [2:0] exp);
        n_checks++;
        assert (sel_ext === exp) else begin
            n_err++;
            $error("FAIL %s: sel_ext=%b expected %b", tag, sel_ext, exp);
        end
    endtask

    // Check the current cycle's controls, then advance to the next negedge
    task automatic cyc(input string tag, input logic [15:0] exp);
        #1;
        chk_ctl(tag, exp);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        Zero      = 1'b0;
        Ins       = 32'h0000_10B7;   // lui x1,1
        repeat (2) @(negedge clk);
        #1;
        chk_ctl("rst_ctl", C_ZERO);
        chk32("rst_instret", instret, 32'd0);
        chk32("rst_instret_wrap", w2_instret, 32'hFFFF_FFFF);
        chk_ext("rst_sel_ext_u", 3'b100);
        @(negedge clk);
        rst_n = 1'b1;

        // lui; also wraps the second instance
        cyc("lui_fetch", C_FETCH_R);
        cyc("lui_decode", C_DECODE);
        chk_ext("lui_sel_ext", 3'b100);
        cyc("lui_exec", C_LUI);
        #1;
        chk32("lui_instret", instret, 32'd1);
        chk32("wrap_instret", w2_instret, 32'd0);

        // add x3,x1,x2
        Ins = 32'h0020_81B3;
        cyc("r_fetch", C_FETCH_R);
        cyc("r_decode", C_DECODE);
        chk_ext("r_sel_ext", 3'b000);
        cyc("r_exec", C_EXECR);
        cyc("r_wb", C_ALUWB);
        #1 chk32("r_instret", instret, 32'd2);

        // lw with two fetch wait cycles
        Ins = 32'h0000_A103;
        mem_ready = 1'b0;
        cyc("lw_fwait0", C_FETCH_W);
        cyc("lw_fwait1", C_FETCH_W);
        mem_ready = 1'b1;
        cyc("lw_fetch", C_FETCH_R);
        cyc("lw_decode", C_DECODE);
        chk_ext("lw_sel_ext", 3'b001);
        cyc("lw_memadr", C_MEMADR);
        cyc("lw_memread", C_MEMREAD);
        cyc("lw_memwb", C_MEMWB);
        #1 chk32("lw_instret", instret, 32'd3);

        // beq taken then not taken
        Ins  = 32'h0020_8463;
        Zero = 1'b1;
        cyc("beqt_fetch", C_FETCH_R);
        chk_ext("beq_sel_ext", 3'b011);
        cyc("beqt_decode", C_DECODE);
        cyc("beqt_exec", C_BEQ_T);
        Zero = 1'b0;
        cyc("beqn_fetch", C_FETCH_R);
        cyc("beqn_decode", C_DECODE);
        cyc("beqn_exec", C_BEQ_N);
        #1 chk32("beq_instret", instret, 32'd5);

        // illegal opcode
        Ins = 32'h0000_007F;
        cyc("ill_fetch", C_FETCH_R);
        chk_ext("ill_sel_ext", 3'b000);
        cyc("ill_decode", C_DEC_ILL);
        #1 chk32("ill_instret", instret, 32'd6);

        // jal x1,8; mem_ready dropped outside memory states has no effect
        Ins = 32'h0080_00EF;
        cyc("jal_fetch", C_FETCH_R);
        chk_ext("jal_sel_ext", 3'b101);
        mem_ready = 1'b0;
        cyc("jal_decode", C_DECODE);
        cyc("jal_exec", C_JAL);
        mem_ready = 1'b1;
        cyc("jal_wb", C_ALUWB);
        #1 chk32("jal_instret", instret, 32'd7);

        // addi x1,x0,5
        Ins = 32'h0050_0093;
        cyc("i_fetch", C_FETCH_R);
        cyc("i_decode", C_DECODE);
        cyc("i_exec", C_EXECI);
        cyc("i_wb", C_ALUWB);
        #1 chk32("i_instret", instret, 32'd8);

        // sw with one write wait
        Ins = 32'h0020_A223;
        cyc("sw_fetch", C_FETCH_R);
        chk_ext("sw_sel_ext", 3'b010);
        cyc("sw_decode", C_DECODE);
        cyc("sw_memadr", C_MEMADR);
        mem_ready = 1'b0;
        cyc("sw_wwait", C_MEMWR_W);
        mem_ready = 1'b1;
        cyc("sw_write", C_MEMWR_R);
        #1 chk32("sw_instret", instret, 32'd9);

        // sw abandoned by reset during a stalled write
        cyc("swr_fetch", C_FETCH_R);
        cyc("swr_decode", C_DECODE);
        cyc("swr_memadr", C_MEMADR);
        mem_ready = 1'b0;
        #1 chk_ctl("swr_wwait", C_MEMWR_W);
        #1 rst_n = 1'b0;
        #1 chk_ctl("swr_rst_async", C_ZERO);
        chk32("swr_rst_instret", instret, 32'd0);
        mem_ready = 1'b1;
        @(negedge clk);
        #1 chk_ctl("swr_rst_hold", C_ZERO);
        chk32("swr_rst_hold_instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_rst_fetch", C_FETCH_R);
        cyc("post_rst_decode", C_DECODE);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
